// File: rtl/tb_tag_ctl_if.sv
// tb_tag_ctl_if
//   Bundles the request side (lookup / fill / flush handshakes) and the
//   tag-array side (address, write data, parity, write strobe, read data)
//   of the translation-buffer tag sequencer.
//   Modports:
//     slave  - the sequencer: takes requests and read data, drives results
//              and the array address/data/strobe.
//     master - the environment: request logic upstream plus the tag RAM.
interface tb_tag_ctl_if #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 15
);
  // lookup handshake
  logic             lk_req;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_done;
  logic             lk_hit;
  logic             lk_perr;
  // fill handshake
  logic             fill_req;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_ack;
  // flush control
  logic             flush_req;
  logic             flush_busy;
  // tag array
  logic [IDX_W-1:0] ta_a;
  logic [TAG_W:0]   ta_d;
  logic             ta_dp;
  logic             ta_nwe;
  logic [TAG_W:0]   ta_q;
  logic             ta_nqp;

  modport slave (
    input  lk_req, lk_idx, lk_tag,
    output lk_done, lk_hit, lk_perr,
    input  fill_req, fill_idx, fill_tag,
    output fill_ack,
    input  flush_req,
    output flush_busy,
    output ta_a, ta_d, ta_dp, ta_nwe,
    input  ta_q, ta_nqp
  );

  modport master (
    output lk_req, lk_idx, lk_tag,
    input  lk_done, lk_hit, lk_perr,
    output fill_req, fill_idx, fill_tag,
    input  fill_ack,
    output flush_req,
    input  flush_busy,
    input  ta_a, ta_d, ta_dp, ta_nwe,
    output ta_q, ta_nqp
  );
endinterface

// File: rtl/tb_tag_ctl.sv
// tb_tag_ctl
//   Sequencer in front of the translation-buffer tag array (2**IDX_W words of
//   {valid, tag} plus one parity bit). Arbitrates flushes, fills and lookups,
//   generates the setup/pulse/hold write timing on the array, compares the
//   read word against the requested tag and checks read parity. A lookup that
//   reads bad parity invalidates (scrubs) the entry it read.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active high
//   bus   - tb_tag_ctl_if.slave:
//           lk_req/lk_idx/lk_tag   -> lk_done/lk_hit/lk_perr   lookup
//           fill_req/fill_idx/fill_tag -> fill_ack             fill
//           flush_req -> flush_busy                            invalidate-all
//           ta_a/ta_d/ta_dp/ta_nwe -> array, ta_q/ta_nqp <- array
// All outputs are registered.
module tb_tag_ctl #(
  parameter int IDX_W      = 8,
  parameter int TAG_W      = 15,
  parameter bit AUTO_FLUSH = 1'b1
) (
  input logic        clk,
  input logic        reset,
  tb_tag_ctl_if.slave bus
);

  localparam int WORD_W = TAG_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LK_RD    = 3'd1,
    W_SETUP  = 3'd2,
    W_PULSE  = 3'd3,
    W_HOLD   = 3'd4,
    FL_SETUP = 3'd5,
    FL_PULSE = 3'd6,
    FL_HOLD  = 3'd7
  } stateT;

  // Even parity over the stored word: stored word plus parity bit has even weight.
  function automatic logic evenParity(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction

  // The array returns its parity bit inverted; an error is any odd weight
  // over {data, true parity}.
  function automatic logic readParityErr(input logic [WORD_W-1:0] word, input logic nParity);
    return ^{word, ~nParity};
  endfunction

  stateT               stateR, stateNxt;
  logic [IDX_W-1:0]    idxR, idxNxt;       // flush entry counter
  logic [TAG_W-1:0]    tagR, tagNxt;       // tag captured when a lookup is accepted
  logic                scrubR, scrubNxt;   // current write is a parity scrub (no ack)
  logic [IDX_W-1:0]    taAR, taANxt;
  logic [WORD_W-1:0]   taDR, taDNxt;
  logic                taDpR, taDpNxt;
  logic                taNweR, taNweNxt;
  logic                lkDoneR, lkDoneNxt;
  logic                lkHitR, lkHitNxt;
  logic                lkPerrR, lkPerrNxt;
  logic                fillAckR, fillAckNxt;
  logic                flushBusyR, flushBusyNxt;

  logic                perrS;
  logic                hitS;
  logic                pulseActiveS;

  // Read-side evaluation of the word currently addressed by ta_a.
  always_comb begin
    perrS = readParityErr(bus.ta_q, bus.ta_nqp);
    hitS  = bus.ta_q[TAG_W] & (bus.ta_q[TAG_W-1:0] == tagR) & ~perrS;
  end

  // State register; reset lands in the flush sequence when the RAM content is unknown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= (AUTO_FLUSH != 1'b0) ? FL_SETUP : IDLE;
    end else begin
      stateR <= stateNxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    stateNxt     = stateR;
    idxNxt       = idxR;
    tagNxt       = tagR;
    scrubNxt     = scrubR;
    taANxt       = taAR;
    taDNxt       = taDR;
    taDpNxt      = taDpR;
    taNweNxt     = 1'b1;
    lkDoneNxt    = 1'b0;
    lkHitNxt     = 1'b0;
    lkPerrNxt    = 1'b0;
    fillAckNxt   = 1'b0;
    flushBusyNxt = flushBusyR;
    // The requester only drops its level request after seeing the pulse,
    // so a request is not re-accepted during the pulse cycle itself.
    pulseActiveS = lkDoneR | fillAckR;

    case (stateR)
      IDLE: begin
        if (bus.flush_req) begin
          stateNxt     = FL_SETUP;
          idxNxt       = {IDX_W{1'b0}};
          taANxt       = {IDX_W{1'b0}};
          taDNxt       = {WORD_W{1'b0}};
          taDpNxt      = 1'b0;
          flushBusyNxt = 1'b1;
        end else if (bus.fill_req && !pulseActiveS) begin
          stateNxt = W_SETUP;
          scrubNxt = 1'b0;
          taANxt   = bus.fill_idx;
          taDNxt   = {1'b1, bus.fill_tag};
          taDpNxt  = evenParity({1'b1, bus.fill_tag});
        end else if (bus.lk_req && !pulseActiveS) begin
          stateNxt = LK_RD;
          taANxt   = bus.lk_idx;
          tagNxt   = bus.lk_tag;
        end else begin
          stateNxt = IDLE;
        end
      end

      LK_RD: begin
        lkDoneNxt = 1'b1;
        lkHitNxt  = hitS;
        lkPerrNxt = perrS;
        if (perrS) begin
          // ta_a still holds the lookup index; invalidate that entry.
          stateNxt = W_SETUP;
          scrubNxt = 1'b1;
          taDNxt   = {WORD_W{1'b0}};
          taDpNxt  = 1'b0;
        end else begin
          stateNxt = IDLE;
        end
      end

      W_SETUP: begin
        stateNxt = W_PULSE;
        taNweNxt = 1'b0;
      end

      W_PULSE: begin
        stateNxt = W_HOLD;
      end

      W_HOLD: begin
        stateNxt   = IDLE;
        fillAckNxt = ~scrubR;
        scrubNxt   = 1'b0;
      end

      FL_SETUP: begin
        stateNxt = FL_PULSE;
        taNweNxt = 1'b0;
      end

      FL_PULSE: begin
        stateNxt = FL_HOLD;
      end

      FL_HOLD: begin
        if (idxR == LAST_IDX) begin
          stateNxt     = IDLE;
          flushBusyNxt = 1'b0;
        end else begin
          stateNxt = FL_SETUP;
          idxNxt   = idxR + IDX_ONE;
          taANxt   = idxR + IDX_ONE;
        end
      end

      default: begin
        stateNxt     = IDLE;
        flushBusyNxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset raises ta_nwe asynchronously so a
  // write pulse in progress is cut off immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idxR       <= {IDX_W{1'b0}};
      tagR       <= {TAG_W{1'b0}};
      scrubR     <= 1'b0;
      taAR       <= {IDX_W{1'b0}};
      taDR       <= {WORD_W{1'b0}};
      taDpR      <= 1'b0;
      taNweR     <= 1'b1;
      lkDoneR    <= 1'b0;
      lkHitR     <= 1'b0;
      lkPerrR    <= 1'b0;
      fillAckR   <= 1'b0;
      flushBusyR <= AUTO_FLUSH;
    end else begin
      idxR       <= idxNxt;
      tagR       <= tagNxt;
      scrubR     <= scrubNxt;
      taAR       <= taANxt;
      taDR       <= taDNxt;
      taDpR      <= taDpNxt;
      taNweR     <= taNweNxt;
      lkDoneR    <= lkDoneNxt;
      lkHitR     <= lkHitNxt;
      lkPerrR    <= lkPerrNxt;
      fillAckR   <= fillAckNxt;
      flushBusyR <= flushBusyNxt;
    end
  end

  assign bus.lk_done    = lkDoneR;
  assign bus.lk_hit     = lkHitR;
  assign bus.lk_perr    = lkPerrR;
  assign bus.fill_ack   = fillAckR;
  assign bus.flush_busy = flushBusyR;
  assign bus.ta_a       = taAR;
  assign bus.ta_d       = taDR;
  assign bus.ta_dp      = taDpR;
  assign bus.ta_nwe     = taNweR;

endmodule

// File: tb/tb_tb_tag_ctl.sv
// tb_tb_tag_ctl
//   Directed bench for tb_tag_ctl with a behavioural 256x17 tag RAM.
//   The RAM writes whatever is on ta_a/ta_d/ta_dp while ta_nwe is low and
//   logs every write; a parity fault can be injected at one index.
module tb_tb_tag_ctl;
  localparam int IDX_W = 8;
  localparam int TAG_W = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tb_tag_ctl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  tb_tag_ctl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .AUTO_FLUSH(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: {parity, valid, tag}
  logic [16:0] mem [0:255];
  logic [24:0] weLog [$];      // {dp, d, a} per write-strobe cycle
  bit          memReady = 1'b0;
  int          ackCnt = 0;
  int          bothPulse = 0;
  logic        flipEn = 1'b0;
  logic [7:0]  flipIdx = 8'h12;

  assign bus.ta_q   = mem[bus.ta_a][15:0];
  assign bus.ta_nqp = ~mem[bus.ta_a][16] ^ (flipEn && (bus.ta_a == flipIdx));

  always @(negedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++) mem[i] = 17'($urandom);
      memReady = 1'b1;
    end
    if (bus.ta_nwe == 1'b0) begin
      mem[bus.ta_a] = {bus.ta_dp, bus.ta_d};
      weLog.push_back({bus.ta_dp, bus.ta_d, bus.ta_a});
    end
    if (bus.fill_ack == 1'b1) ackCnt = ackCnt + 1;
    if (bus.lk_done && bus.fill_ack) bothPulse = bothPulse + 1;
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Counts cycles with flush_busy high, starting at the current negedge.
  task automatic waitFlush(output int cyc);
    int n = 0;
    while (bus.flush_busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    cyc = n;
  endtask

  // Number of logged writes since base that do not match the flush pattern
  // (address counting up from 0, data and parity zero).
  function automatic int flushSeqErrs(input int base);
    int errs = 0;
    for (int i = base; i < weLog.size(); i++) begin
      if (weLog[i] != {17'h0, 8'(i - base)}) errs++;
    end
    return errs;
  endfunction

  // Cycle count is measured from the cycle the request is raised (accept cycle).
  task automatic doFill(input logic [7:0] idx, input logic [14:0] tag, output int lat,
                        output logic [15:0] setD, output logic setDp, output logic [7:0] setA);
    int n = 0;
    setD = 16'h0; setDp = 1'b0; setA = 8'h0;
    bus.fill_idx = idx;
    bus.fill_tag = tag;
    bus.fill_req = 1'b1;
    while (!bus.fill_ack && n < 50) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        setD = bus.ta_d; setDp = bus.ta_dp; setA = bus.ta_a;
      end
    end
    lat = n;
    bus.fill_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic doLookup(input logic [7:0] idx, input logic [14:0] tag, output int lat,
                          output logic hit, output logic perr);
    int n = 0;
    hit = 1'b0; perr = 1'b0;
    bus.lk_idx = idx;
    bus.lk_tag = tag;
    bus.lk_req = 1'b1;
    while (!bus.lk_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    hit = bus.lk_hit;
    perr = bus.lk_perr;
    lat = n;
    bus.lk_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, base, aBase, n, busyCyc, ackAt, doneAt, nz;
    logic [15:0] sd;
    logic sdp, hit, perr, gotHit;
    logic [7:0] sa;

    bus.lk_req = 1'b0; bus.lk_idx = 8'h0; bus.lk_tag = 15'h0;
    bus.fill_req = 1'b0; bus.fill_idx = 8'h0; bus.fill_tag = 15'h0;
    bus.flush_req = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    checkVal("rst_busy", 32'(bus.flush_busy), 32'h1);
    checkVal("rst_nwe", 32'(bus.ta_nwe), 32'h1);
    checkVal("rst_pulses", 32'({bus.lk_done, bus.lk_hit, bus.lk_perr, bus.fill_ack}), 32'h0);
    checkVal("rst_addr", 32'(bus.ta_a), 32'h0);
    checkVal("rst_data", 32'({bus.ta_dp, bus.ta_d}), 32'h0);

    // power-up flush: 3 cycles per entry, 256 strobes at 0..255 writing 0
    base = weLog.size();
    reset = 1'b0;
    waitFlush(lat);
    checkVal("flush_len", 32'(lat), 32'd768);
    checkVal("flush_we_cnt", 32'(weLog.size() - base), 32'd256);
    checkVal("flush_we_seq", 32'(flushSeqErrs(base)), 32'd0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 17'h0) nz++;
    checkVal("flush_ram_clear", 32'(nz), 32'd0);

    // fill: accept cycle + setup/pulse/hold, ack on the 4th cycle
    base = weLog.size();
    doFill(8'h12, 15'h1ABC, lat, sd, sdp, sa);
    checkVal("fill_lat", 32'(lat), 32'd4);
    checkVal("fill_data", 32'(sd), 32'h9ABC);
    checkVal("fill_par", 32'(sdp), 32'h1);
    checkVal("fill_addr", 32'(sa), 32'h12);
    checkVal("fill_nwe_cycles", 32'(weLog.size() - base), 32'd1);
    checkVal("fill_ram", 32'(mem[8'h12]), 32'h19ABC);

    // lookups: hit, tag mismatch, invalid entry whose tag bits match
    doLookup(8'h12, 15'h1ABC, lat, hit, perr);
    checkVal("lk_lat", 32'(lat), 32'd2);
    checkVal("lk_hit", 32'({hit, perr}), 32'h2);
    doLookup(8'h12, 15'h1ABD, lat, hit, perr);
    checkVal("lk_tag_miss", 32'({hit, perr}), 32'h0);
    doLookup(8'h34, 15'h0000, lat, hit, perr);
    checkVal("lk_invalid_miss", 32'({hit, perr}), 32'h0);

    // all-ones tag at the last index: data 0xFFFF has even weight, parity 0
    doFill(8'hFF, 15'h7FFF, lat, sd, sdp, sa);
    checkVal("fill_ff_data", 32'({sdp, sd}), 32'h0FFFF);
    doLookup(8'hFF, 15'h7FFF, lat, hit, perr);
    checkVal("lk_ff_hit", 32'({hit, perr}), 32'h2);

    // parity fault: report perr, then scrub the entry without an ack
    base = weLog.size();
    aBase = ackCnt;
    flipEn = 1'b1;
    doLookup(8'h12, 15'h1ABC, lat, hit, perr);
    checkVal("perr_report", 32'({hit, perr}), 32'h1);
    repeat (4) @(negedge clk);
    flipEn = 1'b0;
    checkVal("scrub_we_cnt", 32'(weLog.size() - base), 32'd1);
    if (weLog.size() > base) checkVal("scrub_write", 32'(weLog[base]), 32'h12);
    else checkVal("scrub_write", 32'hFFFF_FFFF, 32'h12);
    checkVal("scrub_no_ack", 32'(ackCnt - aBase), 32'd0);
    doLookup(8'h12, 15'h1ABC, lat, hit, perr);
    checkVal("relookup_miss", 32'({hit, perr}), 32'h0);

    // flush + fill + lookup in one cycle; flush_req held into the flush
    base = weLog.size();
    bus.flush_req = 1'b1;
    bus.fill_idx = 8'h40; bus.fill_tag = 15'h0123; bus.fill_req = 1'b1;
    bus.lk_idx = 8'h40; bus.lk_tag = 15'h0123; bus.lk_req = 1'b1;
    n = 0; busyCyc = 0; ackAt = -1; doneAt = -1; gotHit = 1'b0;
    while ((ackAt < 0 || doneAt < 0) && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.flush_busy) busyCyc++;
      if (n == 10) bus.flush_req = 1'b0;
      if (bus.fill_ack) begin ackAt = n; bus.fill_req = 1'b0; end
      if (bus.lk_done) begin doneAt = n; gotHit = bus.lk_hit; bus.lk_req = 1'b0; end
    end
    @(negedge clk);
    checkVal("arb_flush_len", 32'(busyCyc), 32'd768);
    checkVal("arb_fill_ack_at", 32'(ackAt), 32'd773);
    checkVal("arb_lk_done_at", 32'(doneAt), 32'd776);
    checkVal("arb_lk_hit", 32'(gotHit), 32'h1);
    checkVal("arb_we_cnt", 32'(weLog.size() - base), 32'd257);

    // reset during the write pulse
    bus.fill_idx = 8'h55; bus.fill_tag = 15'h0001; bus.fill_req = 1'b1;
    n = 0;
    while (bus.ta_nwe && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkVal("rst_reach_pulse", 32'(n), 32'd2);
    reset = 1'b1;
    #1;
    checkVal("rst_mid_nwe", 32'(bus.ta_nwe), 32'h1);
    checkVal("rst_mid_busy", 32'(bus.flush_busy), 32'h1);
    checkVal("rst_mid_addr", 32'(bus.ta_a), 32'h0);
    bus.fill_req = 1'b0;
    @(negedge clk);
    base = weLog.size();
    reset = 1'b0;
    waitFlush(lat);
    checkVal("rst_flush_len", 32'(lat), 32'd768);
    checkVal("rst_flush_we_cnt", 32'(weLog.size() - base), 32'd256);
    checkVal("rst_flush_seq", 32'(flushSeqErrs(base)), 32'd0);
    checkVal("rst_entry_clear", 32'(mem[8'h55]), 32'h0);

    checkVal("done_ack_overlap", 32'(bothPulse), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
